rom_loader: RTL and testbench

- Byte-stream loader between data_io (ioctl_*) and the sdram write port.
- Accepts ROM bytes during a download and issues each as a toggle-handshake SDRAM write, throttling the host with ioctl_wait.
- At end of download, reports the ROM byte count, the 512-byte-header flag and a power-of-two address mask, which the system uses for the header read offset and mapper wrap.

---
 rtl/rom_loader_if.sv | 24 ++
 rtl/rom_loader.sv | 108 ++++++++++
 tb/tb_rom_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_if.sv
// Download-port and SDRAM write-port bundle for the ROM loader.
// master = loader side, slave = host/SDRAM side.
interface rom_loader_if #(
   parameter int AW = 24
);
   logic          ioctl_download;
   logic          ioctl_wr;
   logic [7:0]    ioctl_dout;
   logic          ioctl_wait;
   logic          sd_we;
   logic          sd_wrack;
   logic [AW-1:0] sd_waddr;
   logic [7:0]    sd_din;

   modport master (
      input  ioctl_download, ioctl_wr, ioctl_dout, sd_wrack,
      output ioctl_wait, sd_we, sd_waddr, sd_din
   );

   modport slave (
      output ioctl_download, ioctl_wr, ioctl_dout, sd_wrack,
      input  ioctl_wait, sd_we, sd_waddr, sd_din
   );
endinterface

// File: rtl/rom_loader.sv
// Streams download bytes into SDRAM via a toggle handshake; >=2 cycles per byte.
// The host is held off with ioctl_wait until each write is acknowledged; size/header/mask are reported on done.
module rom_loader #(
   parameter int AW      = 24,
   parameter int HDR_BIT = 9
) (
   input  logic          clk_sys,
   input  logic          RESET_n,
   rom_loader_if.master  io,
   output logic [AW-1:0] rom_size,
   output logic          romhdr,
   output logic [AW-1:0] rom_mask,
   output logic          busy,
   output logic          done,
   output logic          overrun
);
   typedef enum logic [2:0] {SYNC, IDLE, LOAD, ACK, MASK, FIN} state_t;

   localparam logic [AW-1:0] ONE     = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] HDR_LEN = ONE << HDR_BIT;

   state_t        state;
   logic          dl_q;
   logic          dl_pend;
   logic          dl_rise;
   logic [AW-1:0] body;
   logic [AW-1:0] mask_tgt;

   assign dl_rise = io.ioctl_download && !dl_q;
   assign busy    = (state != IDLE) && (state != SYNC);

   // An empty or header-only image clamps the target to 0 instead of wrapping.
   always_comb begin
      body     = romhdr ? (rom_size - HDR_LEN) : rom_size;
      mask_tgt = (body == '0) ? '0 : (body - ONE);
   end

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         state         <= SYNC;
         dl_q          <= 1'b0;
         dl_pend       <= 1'b0;
         io.ioctl_wait <= 1'b0;
         io.sd_we      <= 1'b0;
         io.sd_waddr   <= '0;
         io.sd_din     <= '0;
         rom_size      <= '0;
         romhdr        <= 1'b0;
         rom_mask      <= '0;
         done          <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         dl_q <= io.ioctl_download;
         done <= 1'b0;
         case (state)
            SYNC: begin
               io.sd_we <= io.sd_wrack;
               if (dl_rise) dl_pend <= 1'b1;
               state <= IDLE;
            end
            IDLE: begin
               if (dl_rise || dl_pend) begin
                  dl_pend     <= 1'b0;
                  io.sd_waddr <= '0;
                  rom_size    <= '0;
                  overrun     <= 1'b0;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               if (io.ioctl_wr) begin
                  io.sd_din     <= io.ioctl_dout;
                  io.sd_we      <= ~io.sd_we;
                  io.ioctl_wait <= 1'b1;
                  state         <= ACK;
               end else if (!io.ioctl_download) begin
                  romhdr   <= rom_size[HDR_BIT];
                  rom_mask <= '0;
                  state    <= MASK;
               end
            end
            ACK: begin
               if (io.ioctl_wr) overrun <= 1'b1;
               if (io.sd_we == io.sd_wrack) begin
                  io.ioctl_wait <= 1'b0;
                  io.sd_waddr   <= io.sd_waddr + ONE;
                  rom_size      <= rom_size + ONE;
                  state         <= LOAD;
               end
            end
            MASK: begin
               if (dl_rise) dl_pend <= 1'b1;
               if (rom_mask < mask_tgt) begin
                  rom_mask <= {rom_mask[AW-2:0], 1'b1};
               end else begin
                  done  <= 1'b1;
                  state <= FIN;
               end
            end
            FIN: begin
               if (dl_rise) dl_pend <= 1'b1;
               state <= IDLE;
            end
            default: state <= SYNC;
         endcase
      end
   end
endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: SDRAM responder with programmable ack delay,
// expected writes queued at stimulus time and popped when the DUT issues them.
module tb_rom_loader;
   localparam int AW = 24;

   logic          clk_sys;
   logic          RESET_n;
   logic [AW-1:0] rom_size;
   logic          romhdr;
   logic [AW-1:0] rom_mask;
   logic          busy;
   logic          done;
   logic          overrun;

   rom_loader_if #(.AW(AW)) io ();

   rom_loader #(.AW(AW), .HDR_BIT(9)) dut (
      .clk_sys  (clk_sys),
      .RESET_n  (RESET_n),
      .io       (io.master),
      .rom_size (rom_size),
      .romhdr   (romhdr),
      .rom_mask (rom_mask),
      .busy     (busy),
      .done     (done),
      .overrun  (overrun)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic        wrack_base;
   logic        wrack_tgl;
   int          ack_dly;
   int          obs_wr;
   logic [31:0] obs_buf [64];
   int          done_cnt;

   assign io.sd_wrack = wrack_base ^ wrack_tgl;

   // SDRAM model: record each new request, then acknowledge after ack_dly cycles.
   initial begin
      wrack_tgl = 1'b0;
      obs_wr    = 0;
      forever begin
         @(negedge clk_sys);
         if (RESET_n && busy && (io.sd_we !== io.sd_wrack)) begin
            obs_buf[obs_wr & 63] = {io.sd_waddr, io.sd_din};
            obs_wr++;
            repeat (ack_dly) @(negedge clk_sys);
            if (busy && (io.sd_we !== io.sd_wrack)) wrack_tgl = io.sd_we ^ wrack_base;
         end
      end
   end

   initial begin
      done_cnt = 0;
      forever begin
         @(negedge clk_sys);
         if (done === 1'b1) done_cnt++;
      end
   end

   int          tests;
   int          fails;
   int          rd_idx;
   int          pushed;
   int          hi;
   int          dc0;
   logic [AW-1:0] exp_addr;
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] b);
      exp_q.push_back({exp_addr, b});
      exp_addr = exp_addr + 24'd1;
      pushed++;
   endtask

   task automatic drain();
      logic [31:0] e;
      while ((rd_idx < obs_wr) && (exp_q.size() > 0)) begin
         e = exp_q.pop_front();
         chk("sd_write", obs_buf[rd_idx & 63], e);
         rd_idx++;
      end
   endtask

   task automatic wait_release(output int cycles);
      cycles = 0;
      while ((io.ioctl_wait === 1'b1) && (cycles < 100)) begin
         cycles++;
         @(negedge clk_sys);
      end
      chk("wait_release", 32'(io.ioctl_wait), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, output int cycles);
      io.ioctl_dout = b;
      io.ioctl_wr   = 1'b1;
      push_exp(b);
      @(negedge clk_sys);
      io.ioctl_wr = 1'b0;
      wait_release(cycles);
      drain();
   endtask

   task automatic start_dl();
      exp_addr = '0;
      io.ioctl_download = 1'b1;
      repeat (2) @(negedge clk_sys);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_size", 32'(rom_size), 32'd0);
      chk("start_overrun", 32'(overrun), 32'd0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((done !== 1'b1) && (n < 200)) begin
         n++;
         @(negedge clk_sys);
      end
      chk("done_seen", 32'(done), 32'd1);
   endtask

   initial begin
      tests = 0; fails = 0; rd_idx = 0; pushed = 0; exp_addr = '0;
      RESET_n = 1'b0; wrack_base = 1'b1; ack_dly = 0;
      io.ioctl_download = 1'b0; io.ioctl_wr = 1'b0; io.ioctl_dout = 8'h00;

      // Reset state with sd_wrack high, then SYNC must align sd_we.
      repeat (3) @(negedge clk_sys);
      chk("rst_wait", 32'(io.ioctl_wait), 32'd0);
      chk("rst_sd_we", 32'(io.sd_we), 32'd0);
      chk("rst_waddr", 32'(io.sd_waddr), 32'd0);
      chk("rst_mask", 32'(rom_mask), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      RESET_n = 1'b1;
      @(negedge clk_sys);
      @(negedge clk_sys);
      chk("sync_sd_we", 32'(io.sd_we), 32'd1);
      chk("sync_busy", 32'(busy), 32'd0);
      chk("sync_no_write", 32'(obs_wr), 32'd0);
      chk("sync_done", 32'(done_cnt), 32'd0);

      // Four bytes, immediate ack.
      ack_dly = 0;
      dc0 = done_cnt;
      start_dl();
      send_byte(8'h11, hi); chk("wait_hi_1", 32'(hi), 32'd1);
      send_byte(8'h22, hi); chk("wait_hi_2", 32'(hi), 32'd1);
      send_byte(8'h33, hi); chk("wait_hi_3", 32'(hi), 32'd1);
      send_byte(8'h44, hi); chk("wait_hi_4", 32'(hi), 32'd1);
      io.ioctl_download = 1'b0;
      wait_done();
      chk("t4_size", 32'(rom_size), 32'd4);
      chk("t4_hdr", 32'(romhdr), 32'd0);
      chk("t4_mask", 32'(rom_mask), 32'd3);
      chk("t4_waddr", 32'(io.sd_waddr), 32'd4);
      repeat (3) @(negedge clk_sys);
      chk("t4_done_once", 32'(done_cnt - dc0), 32'd1);
      chk("t4_idle", 32'(busy), 32'd0);
      chk("t4_wr_count", 32'(obs_wr), 32'(pushed));

      // 32K image plus 512-byte copier header.
      start_dl();
      for (int i = 0; i < 32'h8200; i++) send_byte(8'(i * 7 + 3), hi);
      io.ioctl_download = 1'b0;
      wait_done();
      chk("big_size", 32'(rom_size), 32'h8200);
      chk("big_hdr", 32'(romhdr), 32'd1);
      chk("big_mask", 32'(rom_mask), 32'h7FFF);
      chk("big_wr_count", 32'(obs_wr), 32'(pushed));
      repeat (3) @(negedge clk_sys);

      // Slow ack; a second strobe during ACK must be dropped and flagged.
      ack_dly = 5;
      start_dl();
      io.ioctl_dout = 8'hA1; io.ioctl_wr = 1'b1; push_exp(8'hA1);
      @(negedge clk_sys);
      io.ioctl_wr = 1'b0;
      @(negedge clk_sys);
      io.ioctl_dout = 8'hB2; io.ioctl_wr = 1'b1;
      @(negedge clk_sys);
      io.ioctl_wr = 1'b0;
      chk("ovr_flag", 32'(overrun), 32'd1);
      wait_release(hi);
      drain();
      send_byte(8'hC3, hi);
      chk("ovr_wait_hi", 32'(hi), 32'd6);
      io.ioctl_download = 1'b0;
      wait_done();
      chk("ovr_size", 32'(rom_size), 32'd2);
      chk("ovr_sticky", 32'(overrun), 32'd1);
      chk("ovr_mask", 32'(rom_mask), 32'd1);
      chk("ovr_wr_count", 32'(obs_wr), 32'(pushed));
      repeat (3) @(negedge clk_sys);

      // Download ends while a write is still awaiting its ack.
      ack_dly = 4;
      start_dl();
      send_byte(8'h10, hi);
      send_byte(8'h20, hi);
      io.ioctl_dout = 8'h30; io.ioctl_wr = 1'b1; push_exp(8'h30);
      @(negedge clk_sys);
      io.ioctl_wr = 1'b0;
      io.ioctl_download = 1'b0;
      wait_done();
      drain();
      chk("late_acked", 32'(io.sd_we ^ io.sd_wrack), 32'd0);
      chk("late_size", 32'(rom_size), 32'd3);
      chk("late_waddr", 32'(io.sd_waddr), 32'd3);
      chk("late_mask", 32'(rom_mask), 32'd3);
      chk("late_wr_count", 32'(obs_wr), 32'(pushed));
      repeat (3) @(negedge clk_sys);

      // Reset pulsed while a write is outstanding.
      ack_dly = 20;
      start_dl();
      io.ioctl_dout = 8'h5A; io.ioctl_wr = 1'b1; push_exp(8'h5A);
      @(negedge clk_sys);
      io.ioctl_wr = 1'b0;
      chk("abort_wait_hi", 32'(io.ioctl_wait), 32'd1);
      @(negedge clk_sys);
      RESET_n = 1'b0;
      io.ioctl_download = 1'b0;
      #1;
      chk("abort_wait", 32'(io.ioctl_wait), 32'd0);
      chk("abort_sd_we", 32'(io.sd_we), 32'd0);
      chk("abort_din", 32'(io.sd_din), 32'd0);
      chk("abort_mask", 32'(rom_mask), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      drain();
      repeat (30) @(negedge clk_sys);
      RESET_n = 1'b1;
      ack_dly = 0;
      repeat (2) @(negedge clk_sys);
      chk("resync", 32'(io.sd_we ^ io.sd_wrack), 32'd0);
      start_dl();
      send_byte(8'h01, hi);
      send_byte(8'h02, hi);
      io.ioctl_download = 1'b0;
      wait_done();
      chk("restart_size", 32'(rom_size), 32'd2);
      chk("restart_waddr", 32'(io.sd_waddr), 32'd2);
      chk("restart_mask", 32'(rom_mask), 32'd1);
      chk("restart_wr_count", 32'(obs_wr), 32'(pushed));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
